imem_uart_loader: RTL and testbench

//  - UART-fed writer for the instruction memory. The CPU fetch path is the reader of this memory.
//  - Receives a framed program image on a serial RX pin and writes 32-bit words to consecutive word addresses.
//  - Holds the CPU (cpu_hold, drives PC reset/stall in top) while an image is being written.
//  - Sits beside instruction_memory in top and drives its write port.

---
 rtl/imem_uart_loader.sv | 184 ++++++++++++++++++
 tb/tb_imem_uart_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_uart_loader.sv
// UART-fed program loader for the instruction memory: receives 0xA5|L|4*L bytes and writes words.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int INST_MEM_N   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic                  we,
  output logic [INST_MEM_N-1:0] addr,
  output logic [31:0]           wd,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);
  localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [31:0]      DEPTH   = 32'(1 << (INST_MEM_N - 2));
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0]       SYNC    = 8'hA5;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {L_IDLE, L_LEN, L_DATA, L_CHK, L_DONE, L_FAIL} ld_state_t;

  rx_state_t        rx_state;
  logic             rx_s1, rx_s2, rx_prev;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_sh;
  logic             byte_valid, frame_err;

  ld_state_t        ld_state;
  logic [7:0]       len;
  logic [7:0]       word_idx;
  logic [1:0]       byte_idx;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       chk;
`endif

  // Receiver: timer is a down-counter reloaded to half a bit, then full bits, so samples land mid-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= R_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_sh      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= HALF_M1;
            rx_state <= R_START;
          end
        end
        R_START: begin
          if (rx_cnt != '0) rx_cnt <= rx_cnt - 1'b1;
          else if (rx_s2) rx_state <= R_IDLE;
          else begin
            rx_cnt   <= FULL_M1;
            rx_bit   <= '0;
            rx_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (rx_cnt != '0) rx_cnt <= rx_cnt - 1'b1;
          else begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_cnt <= FULL_M1;
            if (rx_bit == 3'd7) rx_state <= R_STOP;
            else rx_bit <= rx_bit + 3'd1;
          end
        end
        R_STOP: begin
          if (rx_cnt != '0) rx_cnt <= rx_cnt - 1'b1;
          else begin
            byte_valid <= rx_s2;
            frame_err  <= !rx_s2;
            rx_state   <= R_IDLE;
          end
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // A framing error aborts from any state; cpu_hold is left as it was so a partial image never runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_state <= L_IDLE;
      len      <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      we       <= 1'b0;
      addr     <= '0;
      wd       <= '0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk      <= '0;
`endif
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      if (frame_err) begin
        err      <= 1'b1;
        ld_state <= L_IDLE;
      end else begin
        case (ld_state)
          L_IDLE, L_FAIL: begin
            if (byte_valid && rx_sh == SYNC) begin
              err      <= 1'b0;
              cpu_hold <= 1'b1;
              ld_state <= L_LEN;
            end
          end
          L_LEN: begin
            if (byte_valid) begin
              if (rx_sh == 8'd0 || 32'(rx_sh) > DEPTH) begin
                err      <= 1'b1;
                ld_state <= L_FAIL;
              end else begin
                len      <= rx_sh;
                word_idx <= '0;
                byte_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
                chk      <= rx_sh;
`endif
                ld_state <= L_DATA;
              end
            end
          end
          L_DATA: begin
            if (byte_valid) begin
              wd[{byte_idx, 3'b000} +: 8] <= rx_sh;
              byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
              chk      <= chk ^ rx_sh;
`endif
              if (byte_idx == 2'd3) begin
                we       <= 1'b1;
                addr     <= INST_MEM_N'({word_idx, 2'b00});
                word_idx <= word_idx + 8'd1;
`ifdef LOADER_CHECKSUM_EN
                if (word_idx == len - 8'd1) ld_state <= L_CHK;
`else
                if (word_idx == len - 8'd1) ld_state <= L_DONE;
`endif
              end
            end
          end
`ifdef LOADER_CHECKSUM_EN
          L_CHK: begin
            if (byte_valid) begin
              if (rx_sh == chk) ld_state <= L_DONE;
              else begin
                err      <= 1'b1;
                ld_state <= L_FAIL;
              end
            end
          end
`endif
          L_DONE: begin
            done     <= 1'b1;
            cpu_hold <= 1'b0;
            ld_state <= L_IDLE;
          end
          default: ld_state <= L_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_imem_uart_loader.sv
// Scoreboard bench for imem_uart_loader: directed UART frames, expected writes/done queued by stimulus.
module tb_imem_uart_loader;
  localparam int CPB    = 16;
  localparam int IMN    = 8;
  localparam int BIT_NS = CPB * 10;

  logic           clk = 1'b0;
  logic           rst;
  logic           rx;
  logic           we;
  logic [IMN-1:0] addr;
  logic [31:0]    wd;
  logic           cpu_hold;
  logic           done;
  logic           err;

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .INST_MEM_N(IMN)) dut (
    .clk(clk), .rst(rst), .rx(rx), .we(we), .addr(addr), .wd(wd),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IMN-1:0] a;
    logic [31:0]    d;
  } wr_t;

  wr_t  wq[$];
  bit   dq[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] run_chk;
  int   widx;
  logic prev_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or a done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (we) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_we: got addr 0x%0h wd 0x%0h expected no write", addr, wd);
        end else begin
          wr_t e;
          e = wq.pop_front();
          check("we_addr", 32'(addr), 32'(e.a));
          check("we_wd", wd, e.d);
        end
        if (prev_we) begin
          checks++; errors++;
          $display("FAIL we_pulse_width: got 2+ cycles expected 1");
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected 0");
        end else begin
          void'(dq.pop_front());
          check("hold_low_at_done", 32'(cpu_hold), 32'd0);
        end
      end
    end
    prev_we = we;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0; #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i]; #(BIT_NS);
    end
    rx = stop; #(BIT_NS);
    rx = 1'b1;
  endtask

  task automatic start_frame(input logic [7:0] len, input bit exp_done);
    if (exp_done) dq.push_back(1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(len, 1'b1);
    run_chk = len;
    widx = 0;
  endtask

  task automatic send_word(input logic [31:0] w);
    wr_t e;
    e.a = IMN'(widx * 4);
    e.d = w;
    wq.push_back(e);
    widx++;
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], 1'b1);
      run_chk = run_chk ^ w[8*i +: 8];
    end
  endtask

  task automatic end_frame(input bit bad);
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad ? 8'h03 : run_chk, 1'b1);
`else
    if (bad) rx = 1'b1;
`endif
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_we"}, 32'(we), 32'd0);
    check({tag, "_addr"}, 32'(addr), 32'd0);
    check({tag, "_wd"}, wd, 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic check_idle_after_load(input string tag);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_pending_wr"}, 32'(wq.size()), 32'd0);
    check({tag, "_pending_done"}, 32'(dq.size()), 32'd0);
  endtask

  initial begin
    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0;
    #(2 * BIT_NS);

    // Two-word image
    start_frame(8'h02, 1'b1);
    send_word(32'h12345678);
    check("hold_during_load", 32'(cpu_hold), 32'd1);
    send_word(32'hDEADBEEF);
    end_frame(1'b0);
    #(3 * BIT_NS);
    check_idle_after_load("load2");

    // Reset in the middle of a received byte
    send_byte(8'hA5, 1'b1);
    #(BIT_NS);
    check("hold_after_sync", 32'(cpu_hold), 32'd1);
    rx = 1'b0;
    #(3 * BIT_NS);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    rx = 1'b1;
    #(2 * BIT_NS);
    @(negedge clk);
    rst = 1'b0;
    #(2 * BIT_NS);

    // Noise before a one-word frame
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    check("noise_no_hold", 32'(cpu_hold), 32'd0);
    start_frame(8'h01, 1'b1);
    send_word(32'h00000001);
    end_frame(1'b0);
    #(3 * BIT_NS);
    check_idle_after_load("noise");

    // Oversized length, then recovery
    start_frame(8'h41, 1'b0);
    #(2 * BIT_NS);
    check("biglen_err", 32'(err), 32'd1);
    check("biglen_hold", 32'(cpu_hold), 32'd1);
    start_frame(8'h01, 1'b1);
    check("err_cleared_by_sync", 32'(err), 32'd0);
    send_word(32'h01020304);
    end_frame(1'b0);
    #(3 * BIT_NS);
    check_idle_after_load("recover");

    // Framing error inside a word; following bytes must not complete it
    start_frame(8'h02, 1'b0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    #(BIT_NS);
    check("frame_err", 32'(err), 32'd1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    #(2 * BIT_NS);
    check("frame_err_sticky", 32'(err), 32'd1);
    check("frame_pending_wr", 32'(wq.size()), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum: words still written, no done
    start_frame(8'h02, 1'b0);
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
    end_frame(1'b1);
    #(3 * BIT_NS);
    check("badchk_err", 32'(err), 32'd1);
    check("badchk_hold", 32'(cpu_hold), 32'd1);
    check("badchk_pending_wr", 32'(wq.size()), 32'd0);
`endif

    check("final_pending_done", 32'(dq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
